// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the HI/LO multiply-divide issue controller.
//   - MD op codes as seen on e_op / hilo_op, with OP_NONE as the idle code
//   - occupancy FSM state encoding
//   - op classification helpers
package md_pkg;

    localparam logic [3:0] OP_MFHI  = 4'd0;
    localparam logic [3:0] OP_MFLO  = 4'd1;
    localparam logic [3:0] OP_MTHI  = 4'd2;
    localparam logic [3:0] OP_MTLO  = 4'd3;
    localparam logic [3:0] OP_MULTU = 4'd4;
    localparam logic [3:0] OP_DIVU  = 4'd5;
    localparam logic [3:0] OP_MULT  = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_NONE  = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUED = 2'd1,
        RUN    = 2'd2
    } md_state_e;

    // Codes 0-7 are MD ops; anything with bit 3 set is not.
    function automatic logic is_md_op(input logic [3:0] op);
        return ~op[3];
    endfunction

    // MULTU/DIVU/MULT/DIV (4-7) start a multi-cycle unit operation.
    function automatic logic is_start_op(input logic [3:0] op);
        return ~op[3] & op[2];
    endfunction

endpackage

// File: rtl/md_perf_cnt.sv
// md_perf_cnt: saturating event counter.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low clear
//   inc   - count this cycle
//   cnt   - current count; holds at all-ones instead of wrapping
module md_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue/stall control between the E stage and the shared
// HI/LO multiply-divide unit.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no start op outstanding
// ISSUED | start op driven last cycle, waiting for the unit to go busy
// RUN    | unit busy with our op; lat_cnt counts busy cycles
//
// Ports:
//   clk, reset     - clock (rising edge), async active-low reset
//   e_valid, e_op  - E-stage instruction and its MD op code
//   e_adv          - E instruction moves to M at this edge
//   flush          - E instruction cancelled this cycle
//   hilo_busy      - busy flag from the MD unit
//   hilo_op        - op to the MD unit, OP_NONE when idle
//   stall          - hold F/D/E
//   md_done        - pulse on the first non-busy cycle after RUN
//   lat_err        - sticky: unit ignored an op or ran MAX_LAT cycles
//   stall_cnt      - saturating count of stall cycles
//   issue_cnt      - saturating count of start ops issued
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MAX_LAT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    input  logic [3:0]       e_op,
    input  logic             e_adv,
    input  logic             flush,
    input  logic             hilo_busy,
    output logic [3:0]       hilo_op,
    output logic             stall,
    output logic             md_done,
    output logic             lat_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MAX_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    md_state_e        state;
    logic             issued;
    logic [LAT_W-1:0] lat_cnt;

    logic is_md;
    logic is_read;
    logic can_drive;
    logic issue_wr;
    logic issue_start;

    assign is_md     = e_valid & is_md_op(e_op);
    assign is_read   = (e_op[3:1] == 3'b000);
    assign can_drive = is_md & ~hilo_busy & ~flush;

    // Reads may be re-driven every cycle; writes and starts go out once
    // per instruction, guarded by the issued flag while E is held.
    assign issue_wr    = can_drive & ~is_read & ~issued;
    assign issue_start = issue_wr & is_start_op(e_op);

    assign hilo_op = (can_drive & (is_read | ~issued)) ? e_op : OP_NONE;
    assign stall   = is_md & hilo_busy & ~flush;
    assign md_done = (state == RUN) & ~hilo_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            issued  <= 1'b0;
            lat_cnt <= '0;
            lat_err <= 1'b0;
        end else begin
            if (e_adv || flush) begin
                issued <= 1'b0;
            end else if (issue_wr) begin
                issued <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (issue_start) begin
                        state <= ISSUED;
                    end
                end
                ISSUED: begin
                    if (hilo_busy) begin
                        state   <= RUN;
                        lat_cnt <= '0;
                    end else begin
                        // Unit never acknowledged the start.
                        state   <= IDLE;
                        lat_err <= 1'b1;
                    end
                end
                RUN: begin
                    if (!hilo_busy) begin
                        state <= IDLE;
                    end else begin
                        if (lat_cnt != LAT_MAX) begin
                            lat_cnt <= lat_cnt + LAT_ONE;
                        end
                        if (lat_cnt == LAT_LAST) begin
                            lat_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    md_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .cnt   (stall_cnt)
    );

    md_perf_cnt #(.CNT_W(CNT_W)) u_issue_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (issue_start),
        .cnt   (issue_cnt)
    );

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl (CNT_W=4 so saturation is reachable).
module tb_md_issue_ctrl;
    import md_pkg::*;

    localparam int MAX_LAT = 16;
    localparam int CNT_W   = 4;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             e_valid, e_adv, flush, hilo_busy;
    logic [3:0]       e_op;
    logic [3:0]       hilo_op;
    logic             stall, md_done, lat_err;
    logic [CNT_W-1:0] stall_cnt, issue_cnt;

    md_issue_ctrl #(.MAX_LAT(MAX_LAT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .e_valid   (e_valid),
        .e_op      (e_op),
        .e_adv     (e_adv),
        .flush     (flush),
        .hilo_busy (hilo_busy),
        .hilo_op   (hilo_op),
        .stall     (stall),
        .md_done   (md_done),
        .lat_err   (lat_err),
        .stall_cnt (stall_cnt),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: instruction-level bookkeeping.
    bit m_issued;      // current E instruction already sent its write/start
    bit m_wait;        // a start went out last cycle, unit not yet seen busy
    bit m_run;         // unit busy on our start
    int m_run_cycles;  // busy cycles seen since the acknowledge cycle
    bit m_lat_err;
    int m_stall_cnt, m_issue_cnt;

    logic [3:0] x_op;
    bit         x_stall, x_done;

    // Outputs sampled mid-cycle by the last call to cyc.
    logic [3:0] s_op;
    logic       s_stall, s_done, s_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_issued = 0; m_wait = 0; m_run = 0; m_run_cycles = 0;
        m_lat_err = 0; m_stall_cnt = 0; m_issue_cnt = 0;
    endtask

    task automatic model_comb(input logic v, input logic [3:0] op, input logic fl, input logic bz);
        bit md;
        md      = v && (op < 8);
        x_stall = md && bz && !fl;
        x_op    = OP_NONE;
        if (md && !bz && !fl) begin
            if (op < 2 || !m_issued) x_op = op;
        end
        x_done = m_run && !bz;
    endtask

    task automatic model_next(input logic adv, input logic fl, input logic bz);
        bit start_drv, wr_drv;
        start_drv = (x_op >= 4) && (x_op <= 7);
        wr_drv    = (x_op >= 2) && (x_op <= 7);
        if (x_stall && m_stall_cnt < SAT) m_stall_cnt++;
        if (start_drv && m_issue_cnt < SAT) m_issue_cnt++;
        if (m_wait) begin
            m_wait = 0;
            if (bz) begin
                m_run = 1;
                m_run_cycles = 0;
            end else begin
                m_lat_err = 1;
            end
        end else if (m_run) begin
            if (!bz) begin
                m_run = 0;
            end else begin
                m_run_cycles++;
                if (m_run_cycles >= MAX_LAT) m_lat_err = 1;
            end
        end else if (start_drv) begin
            m_wait = 1;
        end
        if (adv || fl) m_issued = 0;
        else if (wr_drv) m_issued = 1;
    endtask

    // One clock cycle: drive, check every output against the model mid-cycle,
    // advance the model across the edge.
    task automatic cyc(input logic v, input logic [3:0] op, input logic adv,
                       input logic fl, input logic bz);
        e_valid = v; e_op = op; e_adv = adv; flush = fl; hilo_busy = bz;
        @(negedge clk);
        model_comb(v, op, fl, bz);
        s_op = hilo_op; s_stall = stall; s_done = md_done; s_lat = lat_err;
        chk("hilo_op",   32'(hilo_op),   32'(x_op));
        chk("stall",     32'(stall),     32'(x_stall));
        chk("md_done",   32'(md_done),   32'(x_done));
        chk("lat_err",   32'(lat_err),   32'(m_lat_err));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
        chk("issue_cnt", 32'(issue_cnt), 32'(m_issue_cnt));
        model_next(adv, fl, bz);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_op"},     32'(hilo_op),   32'hF);
        chk({tag, "_stall"},  32'(stall),     32'd0);
        chk({tag, "_done"},   32'(md_done),   32'd0);
        chk({tag, "_laterr"}, 32'(lat_err),   32'd0);
        chk({tag, "_scnt"},   32'(stall_cnt), 32'd0);
        chk({tag, "_icnt"},   32'(issue_cnt), 32'd0);
    endtask

    task automatic do_reset();
        e_valid = 0; e_op = 4'hF; e_adv = 0; flush = 0; hilo_busy = 0;
        #2;
        reset = 0;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       v;
        logic [3:0] op;
        logic       fl;
        logic       bz;
        logic [3:0] exp_op;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[13];
    int   busy_left;

    initial begin
        vecs[0]  = '{1'b1, 4'd0,  1'b0, 1'b0, 4'd0, 1'b0};
        vecs[1]  = '{1'b1, 4'd1,  1'b0, 1'b1, 4'hF, 1'b1};
        vecs[2]  = '{1'b1, 4'd2,  1'b0, 1'b0, 4'd2, 1'b0};
        vecs[3]  = '{1'b1, 4'd3,  1'b1, 1'b0, 4'hF, 1'b0};
        vecs[4]  = '{1'b1, 4'd4,  1'b0, 1'b0, 4'd4, 1'b0};
        vecs[5]  = '{1'b1, 4'd5,  1'b0, 1'b1, 4'hF, 1'b1};
        vecs[6]  = '{1'b1, 4'd6,  1'b1, 1'b1, 4'hF, 1'b0};
        vecs[7]  = '{1'b1, 4'd7,  1'b0, 1'b0, 4'd7, 1'b0};
        vecs[8]  = '{1'b1, 4'd8,  1'b0, 1'b1, 4'hF, 1'b0};
        vecs[9]  = '{1'b1, 4'd15, 1'b0, 1'b0, 4'hF, 1'b0};
        vecs[10] = '{1'b0, 4'd6,  1'b0, 1'b0, 4'hF, 1'b0};
        vecs[11] = '{1'b0, 4'd1,  1'b0, 1'b1, 4'hF, 1'b0};
        vecs[12] = '{1'b1, 4'd3,  1'b0, 1'b1, 4'hF, 1'b1};

        reset = 1;
        e_valid = 0; e_op = 4'hF; e_adv = 0; flush = 0; hilo_busy = 0;
        #3;
        reset = 0;
        #1;
        model_reset();
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;

        // Decode table: each vector from a fresh reset, issued flag clear.
        for (int i = 0; i < 13; i++) begin
            do_reset();
            cyc(vecs[i].v, vecs[i].op, 1'b0, vecs[i].fl, vecs[i].bz);
            chk($sformatf("vec%0d_op", i), 32'(s_op), 32'(vecs[i].exp_op));
            chk($sformatf("vec%0d_stall", i), 32'(s_stall), 32'(vecs[i].exp_stall));
        end

        // MULT then dependent MFLO.
        do_reset();
        cyc(1, OP_MULT, 1, 0, 0);
        chk("mult_issue_op", 32'(s_op), 32'd6);
        for (int k = 1; k <= 5; k++) begin
            cyc(1, OP_MFLO, 0, 0, 1);
            chk("mflo_stall", 32'(s_stall), 32'd1);
            chk("mflo_held_op", 32'(s_op), 32'hF);
        end
        cyc(1, OP_MFLO, 1, 0, 0);
        chk("mflo_op", 32'(s_op), 32'd1);
        chk("mult_done", 32'(s_done), 32'd1);
        chk("mult_issue_cnt", 32'(issue_cnt), 32'd1);
        chk("mult_stall_cnt", 32'(stall_cnt), 32'd5);
        cyc(0, 4'hF, 0, 0, 0);
        chk("done_one_cycle", 32'(s_done), 32'd0);
        chk("mult_no_laterr", 32'(s_lat), 32'd0);

        // DIVU with E held: single issue until e_adv.
        do_reset();
        cyc(1, OP_DIVU, 0, 0, 0);
        chk("divu_issue", 32'(s_op), 32'd5);
        cyc(1, OP_DIVU, 0, 0, 0);
        chk("divu_held1", 32'(s_op), 32'hF);
        cyc(1, OP_DIVU, 1, 0, 0);
        chk("divu_held2", 32'(s_op), 32'hF);
        chk("divu_icnt1", 32'(issue_cnt), 32'd1);
        cyc(1, OP_DIVU, 1, 0, 0);
        chk("divu_next_instr", 32'(s_op), 32'd5);
        chk("divu_icnt2", 32'(issue_cnt), 32'd2);

        // MTHI held off by a busy unit, then issued once.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(1, OP_MTHI, 0, 0, 1);
            chk("mthi_stall", 32'(s_stall), 32'd1);
            chk("mthi_wait_op", 32'(s_op), 32'hF);
        end
        cyc(1, OP_MTHI, 0, 0, 0);
        chk("mthi_issue", 32'(s_op), 32'd2);
        chk("mthi_nostall", 32'(s_stall), 32'd0);
        cyc(1, OP_MTHI, 1, 0, 0);
        chk("mthi_once", 32'(s_op), 32'hF);

        // Flush beats issue.
        do_reset();
        cyc(1, OP_DIV, 0, 1, 0);
        chk("flush_op", 32'(s_op), 32'hF);
        chk("flush_stall", 32'(s_stall), 32'd0);
        cyc(0, 4'hF, 0, 0, 0);
        cyc(0, 4'hF, 0, 0, 0);
        chk("flush_icnt", 32'(issue_cnt), 32'd0);
        chk("flush_idle", 32'(lat_err), 32'd0);

        // Latency overrun, then reset mid-RUN.
        do_reset();
        cyc(1, OP_MULT, 1, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 4'hF, 0, 0, 1);
            chk($sformatf("lat_k%0d", k), 32'(s_lat), 32'(k >= 18));
        end
        #2;
        reset = 0;
        #1;
        model_reset();
        check_reset_vals("midrun");
        @(negedge clk);
        reset = 1;
        hilo_busy = 0;
        @(posedge clk);
        #1;

        // Stall counter saturation.
        do_reset();
        for (int k = 0; k < SAT + 4; k++) cyc(1, OP_MFHI, 0, 0, 1);
        chk("stall_cnt_sat", 32'(stall_cnt), 32'(SAT));

        // Randomized traffic with a behavioural MD unit.
        busy_left = 0;
        for (int n = 0; n < 800; n++) begin
            logic v, adv, fl, bz;
            logic [3:0] op;
            int r;
            if (n % 80 == 0) begin
                do_reset();
                busy_left = 0;
            end
            v   = ($urandom % 4) != 0;
            op  = 4'($urandom % 11);
            adv = ($urandom % 3) == 0;
            fl  = ($urandom % 10) == 0;
            bz  = busy_left > 0;
            cyc(v, op, adv, fl, bz);
            if (bz) busy_left--;
            if (x_op >= 4 && x_op <= 7) begin
                r = $urandom % 20;
                if (r == 0)      busy_left = 0;
                else if (r < 3)  busy_left = 20;
                else             busy_left = x_op[0] ? 10 : 5;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
